// File: rtl/patch_extremum_sequencer_pkg.sv
// Shared constants for the patch extremum sequencer: default sample width,
// FSM state encoding and the min/max tracking mode selectors.
package patch_extremum_sequencer_pkg;

    localparam int DATA_W_DEF = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_OUT   = 2'd2;

    localparam int MODE_MIN = 0;
    localparam int MODE_MAX = 1;

    // Index/counter width; a single-sample window still needs one bit.
    function automatic int idx_width(input int win_len);
        return (win_len > 1) ? $clog2(win_len) : 1;
    endfunction

endpackage

// File: rtl/patch_extremum_sequencer_gt_compare.sv
// Unsigned strict greater-than shared by min and max tracking; the caller
// swaps operands to select the mode.
module gt_compare
    import patch_extremum_sequencer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_gt
);

    assign o_gt = (i_a > i_b);

endmodule

// File: rtl/patch_extremum_sequencer.sv
// Streams one window of samples through a single comparator and reports the
// extremum value and its earliest position on a valid/ready output.
module patch_extremum_sequencer
    import patch_extremum_sequencer_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int WIN_LEN  = 9,
    parameter int FIND_MAX = MODE_MIN,
    parameter int IDX_W    = idx_width(WIN_LEN)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic [IDX_W-1:0]  o_out_idx,
    output logic              o_busy
);

    localparam bit             TRACK_MAX = (FIND_MAX == MODE_MAX);
    localparam logic [IDX_W-1:0] LAST_CNT  = IDX_W'(WIN_LEN - 1);
    localparam logic [IDX_W-1:0] FIRST_CNT = (WIN_LEN == 1) ? IDX_W'(0) : IDX_W'(1);
    localparam logic [1:0]       AFTER_FIRST = (WIN_LEN == 1) ? ST_OUT : ST_ACCUM;

    logic [1:0]        r_state;
    logic [IDX_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_best;
    logic [IDX_W-1:0]  r_best_idx;
    logic              r_out_valid;
    logic              r_in_ready;
    logic              r_busy;

    logic [1:0]        w_state_nxt;
    logic [IDX_W-1:0]  w_cnt_nxt;
    logic [DATA_W-1:0] w_best_nxt;
    logic [IDX_W-1:0]  w_best_idx_nxt;
    logic [DATA_W-1:0] w_cmp_a;
    logic [DATA_W-1:0] w_cmp_b;
    logic              w_gt;
    logic              w_accept;
    logic              w_consume;

    assign w_accept  = i_in_valid & r_in_ready;
    assign w_consume = r_out_valid & i_out_ready;

    // Min mode replaces best when best > sample; max mode when sample > best.
    assign w_cmp_a = TRACK_MAX ? i_in_data : r_best;
    assign w_cmp_b = TRACK_MAX ? r_best : i_in_data;

    gt_compare #(
        .DATA_W (DATA_W)
    ) u_gt_compare (
        .i_a  (w_cmp_a),
        .i_b  (w_cmp_b),
        .o_gt (w_gt)
    );

    // Next-state, counter and running-extremum decode; clear overrides all.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_best_nxt     = r_best;
        w_best_idx_nxt = r_best_idx;
        if (i_clear) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = IDX_W'(0);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_best_nxt     = i_in_data;
                        w_best_idx_nxt = IDX_W'(0);
                        w_cnt_nxt      = FIRST_CNT;
                        w_state_nxt    = AFTER_FIRST;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_ACCUM: begin
                    if (w_accept) begin
                        if (w_gt) begin
                            w_best_nxt     = i_in_data;
                            w_best_idx_nxt = r_cnt;
                        end else begin
                            w_best_nxt     = r_best;
                        end
                        // Counter wraps via the state change so it never exceeds WIN_LEN-1.
                        if (r_cnt == LAST_CNT) begin
                            w_cnt_nxt   = IDX_W'(0);
                            w_state_nxt = ST_OUT;
                        end else begin
                            w_cnt_nxt   = r_cnt + IDX_W'(1);
                        end
                    end else begin
                        w_state_nxt = ST_ACCUM;
                    end
                end
                ST_OUT: begin
                    if (w_consume) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = IDX_W'(0);
                    end else begin
                        w_state_nxt = ST_OUT;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = IDX_W'(0);
                end
            endcase
        end
    end

    // State, datapath and handshake flags all registered from the next state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= IDX_W'(0);
            r_best      <= DATA_W'(0);
            r_best_idx  <= IDX_W'(0);
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_best      <= w_best_nxt;
            r_best_idx  <= w_best_idx_nxt;
            r_out_valid <= (w_state_nxt == ST_OUT);
            r_in_ready  <= (w_state_nxt != ST_OUT);
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_best;
    assign o_out_idx   = r_best_idx;
    assign o_busy      = r_busy;

endmodule
